// File: rtl/line_clear_controller.sv
// Post-lock line clear sequencer: scans the captured board bottom to top, removes
// full rows by shifting everything above them down, writes the result back and scores it.
module line_clear_controller #(
  parameter int ROWS    = 23,
  parameter int COLS    = 10,
  parameter int SCORE_W = 20
) (
  input  logic                   clk_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   board_in,
  input  logic                   clear_score,
  output logic                   busy,
  output logic [ROWS*COLS-1:0]   board_out,
  output logic                   board_we,
  output logic                   done,
  output logic [4:0]             lines_cleared,
  output logic [SCORE_W-1:0]     score,
  output logic [15:0]            total_lines
);

  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, WRITE, DONE} state_t;

  state_t               state, next_state;
  logic [ROWS*COLS-1:0] brd;
  logic [ROW_W-1:0]     row_ptr;
  logic [4:0]           cnt;
  logic                 row_full;
  logic [SCORE_W-1:0]   pts;
  logic [SCORE_W:0]     score_sum;
  logic [16:0]          lines_sum;

  assign row_full  = &brd[int'(row_ptr)*COLS +: COLS];
  assign busy      = (state != IDLE);
  assign board_we  = (state == WRITE);
  assign done      = (state == DONE);
  assign score_sum = {1'b0, score} + {1'b0, pts};
  assign lines_sum = {1'b0, total_lines} + 17'(cnt);

  always_ff @(posedge clk_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CHECK;
      CHECK: begin
        if (row_full)          next_state = SHIFT;
        else if (row_ptr == 0) next_state = WRITE;
      end
      SHIFT:   next_state = CHECK;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pts = '0;
    case (cnt)
      5'd0:    pts = '0;
      5'd1:    pts = SCORE_W'(40);
      5'd2:    pts = SCORE_W'(100);
      5'd3:    pts = SCORE_W'(300);
      default: pts = SCORE_W'(1200);
    endcase
  end

  // board_out and lines_cleared are latched on the way into WRITE so they are valid with the strobe
  always_ff @(posedge clk_50) begin
    if (reset) begin
      brd           <= '0;
      row_ptr       <= ROW_W'(ROWS-1);
      cnt           <= '0;
      board_out     <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            brd     <= board_in;
            row_ptr <= ROW_W'(ROWS-1);
            cnt     <= '0;
          end
        end
        CHECK: begin
          if (!row_full) begin
            if (row_ptr != 0) begin
              row_ptr <= row_ptr - 1'b1;
            end else begin
              board_out     <= brd;
              lines_cleared <= cnt;
            end
          end
        end
        SHIFT: begin
          for (int k = 1; k < ROWS; k++) begin
            if (k <= int'(row_ptr)) brd[k*COLS +: COLS] <= brd[(k-1)*COLS +: COLS];
          end
          brd[0 +: COLS] <= '0;
          cnt            <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset || clear_score) begin
      score       <= '0;
      total_lines <= '0;
    end else if (state == DONE) begin
      score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      total_lines <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
    end
  end

endmodule

// File: tb/tb_line_clear_controller.sv
// Directed bench for line_clear_controller: latency, compaction, scoring, reset abort, saturation.
module tb_line_clear_controller;
  localparam int ROWS = 23;
  localparam int COLS = 10;
  localparam int BW   = ROWS*COLS;

  logic          clk_50 = 1'b0;
  logic          reset, start, clear_score;
  logic [BW-1:0] board_in, board_out;
  logic          busy, board_we, done;
  logic [4:0]    lines_cleared;
  logic [19:0]   score;
  logic [15:0]   total_lines;

  int tests = 0;
  int fails = 0;

  int            done_cyc, we_cyc, we_cnt, busy_err;
  logic [BW-1:0] bout;
  logic [4:0]    lc;

  line_clear_controller #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(20)) dut (
    .clk_50(clk_50), .reset(reset), .start(start), .board_in(board_in),
    .clear_score(clear_score), .busy(busy), .board_out(board_out),
    .board_we(board_we), .done(done), .lines_cleared(lines_cleared),
    .score(score), .total_lines(total_lines)
  );

  always #5 clk_50 = ~clk_50;

  // Pulses start in cycle 0 and records when the strobe and done occur, relative to it
  task automatic launch(input logic [BW-1:0] b, input int restart_cyc, input logic clr);
    done_cyc = -1; we_cyc = -1; we_cnt = 0; busy_err = 0;
    @(negedge clk_50); board_in = b; start = 1'b1;
    for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
      @(negedge clk_50);
      start = (cyc == restart_cyc);
      if (busy !== 1'b1) busy_err++;
      if (board_we === 1'b1) begin we_cnt++; we_cyc = cyc; bout = board_out; end
      if (done === 1'b1) begin done_cyc = cyc; lc = lines_cleared; clear_score = clr; end
    end
    start = 1'b0;
    @(negedge clk_50); clear_score = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; clear_score = 1'b0; board_in = '0;
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
    tests++; if ({busy, board_we, done} !== 3'b000) begin fails++; $display("[TB] FAIL reset_ctrl got %b want 000", {busy, board_we, done}); end
    tests++; if (board_out !== '0) begin fails++; $display("[TB] FAIL reset_board_out got %h want 0", board_out); end
    tests++; if ({lines_cleared, score, total_lines} !== 41'd0) begin fails++; $display("[TB] FAIL reset_counts lc=%0d score=%0d total=%0d want 0", lines_cleared, score, total_lines); end
  endtask

  task automatic test_empty;
    launch('0, -1, 1'b0);
    tests++; if (we_cyc !== 24) begin fails++; $display("[TB] FAIL empty_we_cycle got %0d want 24", we_cyc); end
    tests++; if (done_cyc !== 25) begin fails++; $display("[TB] FAIL empty_done_cycle got %0d want 25", done_cyc); end
    tests++; if (bout !== '0) begin fails++; $display("[TB] FAIL empty_board got %h want 0", bout); end
    tests++; if (lc !== 5'd0) begin fails++; $display("[TB] FAIL empty_lines got %0d want 0", lc); end
    tests++; if (busy_err !== 0) begin fails++; $display("[TB] FAIL empty_busy_window got %0d low cycles want 0", busy_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL empty_busy_after got %b want 0", busy); end
    tests++; if (score !== 20'd0) begin fails++; $display("[TB] FAIL empty_score got %0d want 0", score); end
  endtask

  task automatic test_single;
    logic [BW-1:0] b, e;
    b = '0; b[22*COLS +: COLS] = 10'h3FF; b[21*COLS +: COLS] = 10'h201;
    e = '0; e[22*COLS +: COLS] = 10'h201;
    launch(b, -1, 1'b0);
    tests++; if (done_cyc !== 27) begin fails++; $display("[TB] FAIL single_done_cycle got %0d want 27", done_cyc); end
    tests++; if (bout !== e) begin fails++; $display("[TB] FAIL single_board got %h want %h", bout, e); end
    tests++; if (lc !== 5'd1) begin fails++; $display("[TB] FAIL single_lines got %0d want 1", lc); end
    tests++; if (score !== 20'd40) begin fails++; $display("[TB] FAIL single_score got %0d want 40", score); end
    tests++; if (total_lines !== 16'd1) begin fails++; $display("[TB] FAIL single_total got %0d want 1", total_lines); end
  endtask

  task automatic test_tetris;
    logic [BW-1:0] b, e;
    b = '0;
    for (int r = 19; r <= 22; r++) b[r*COLS +: COLS] = 10'h3FF;
    b[18*COLS +: COLS] = 10'h00F;
    e = '0; e[22*COLS +: COLS] = 10'h00F;
    launch(b, -1, 1'b0);
    tests++; if (done_cyc !== 33) begin fails++; $display("[TB] FAIL tetris_done_cycle got %0d want 33", done_cyc); end
    tests++; if (bout !== e) begin fails++; $display("[TB] FAIL tetris_board got %h want %h", bout, e); end
    tests++; if (lc !== 5'd4) begin fails++; $display("[TB] FAIL tetris_lines got %0d want 4", lc); end
    tests++; if (score !== 20'd1240) begin fails++; $display("[TB] FAIL tetris_score got %0d want 1240", score); end
    tests++; if (total_lines !== 16'd5) begin fails++; $display("[TB] FAIL tetris_total got %0d want 5", total_lines); end
  endtask

  task automatic test_gap_rows;
    logic [BW-1:0] b, e;
    b = '0;
    b[22*COLS +: COLS] = 10'h3FF; b[21*COLS +: COLS] = 10'h0F0;
    b[20*COLS +: COLS] = 10'h3FF; b[19*COLS +: COLS] = 10'h001;
    e = '0; e[22*COLS +: COLS] = 10'h0F0; e[21*COLS +: COLS] = 10'h001;
    launch(b, 5, 1'b0);
    tests++; if (done_cyc !== 29) begin fails++; $display("[TB] FAIL gap_done_cycle got %0d want 29", done_cyc); end
    tests++; if (we_cnt !== 1) begin fails++; $display("[TB] FAIL gap_we_count got %0d want 1", we_cnt); end
    tests++; if (bout !== e) begin fails++; $display("[TB] FAIL gap_board got %h want %h", bout, e); end
    tests++; if (lc !== 5'd2) begin fails++; $display("[TB] FAIL gap_lines got %0d want 2", lc); end
    tests++; if (score !== 20'd1340) begin fails++; $display("[TB] FAIL gap_score got %0d want 1340", score); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL gap_no_restart busy got %b want 0", busy); end
  endtask

  task automatic test_reset_abort;
    logic [BW-1:0] b;
    int seen;
    b = '0; b[22*COLS +: COLS] = 10'h3FF;
    @(negedge clk_50); board_in = b; start = 1'b1;
    @(negedge clk_50); start = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk_50);
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (board_we === 1'b1 || done === 1'b1) seen++;
      @(negedge clk_50);
    end
    tests++; if (seen !== 0) begin fails++; $display("[TB] FAIL abort_no_write got %0d strobes want 0", seen); end
    tests++; if (score !== 20'd0 || total_lines !== 16'd0) begin fails++; $display("[TB] FAIL abort_counts score=%0d total=%0d want 0", score, total_lines); end
    launch(b, -1, 1'b0);
    tests++; if (done_cyc !== 27 || lc !== 5'd1) begin fails++; $display("[TB] FAIL abort_rerun done=%0d lines=%0d want 27 1", done_cyc, lc); end
    tests++; if (score !== 20'd40) begin fails++; $display("[TB] FAIL abort_rerun_score got %0d want 40", score); end
  endtask

  task automatic test_saturation;
    logic [BW-1:0] b;
    b = '0;
    for (int r = 19; r <= 22; r++) b[r*COLS +: COLS] = 10'h3FF;
    // 40 + 873*1200 = 1047640; one more clear exceeds 2^20-1
    for (int i = 0; i < 873; i++) launch(b, -1, 1'b0);
    tests++; if (score !== 20'd1047640) begin fails++; $display("[TB] FAIL sat_preload got %0d want 1047640", score); end
    launch(b, -1, 1'b0);
    tests++; if (score !== 20'd1048575) begin fails++; $display("[TB] FAIL sat_score got %0d want 1048575", score); end
    tests++; if (total_lines !== 16'd3497) begin fails++; $display("[TB] FAIL sat_total got %0d want 3497", total_lines); end
    launch(b, -1, 1'b0);
    tests++; if (score !== 20'd1048575) begin fails++; $display("[TB] FAIL sat_hold got %0d want 1048575", score); end
    launch(b, -1, 1'b1);
    tests++; if (score !== 20'd0 || total_lines !== 16'd0) begin fails++; $display("[TB] FAIL clear_in_done score=%0d total=%0d want 0", score, total_lines); end
  endtask

  task automatic test_all_full;
    logic [BW-1:0] b;
    b = '1;
    launch(b, -1, 1'b0);
    tests++; if (lc !== 5'd23) begin fails++; $display("[TB] FAIL full_lines got %0d want 23", lc); end
    tests++; if (bout !== '0) begin fails++; $display("[TB] FAIL full_board got %h want 0", bout); end
    tests++; if (done_cyc !== 71) begin fails++; $display("[TB] FAIL full_done_cycle got %0d want 71", done_cyc); end
  endtask

  initial begin
    test_reset;
    test_empty;
    test_single;
    test_tetris;
    test_gap_rows;
    test_reset_abort;
    test_saturation;
    test_all_full;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/line_clear_controller.md
Name: line_clear_controller

Overview:
Sequences the post-lock step of the game after a falling piece has been stacked. It captures the 23x10 board and scans rows from bottom to top. Each full row is removed and everything above it is shifted down. The compacted board is written back to the board state store, and running score and line totals are updated. It sits between the board state recorder and the top-level game FSM, which pulses start when a piece locks and waits for done.

Parameters:
ROWS, 23, board rows (row 0 = top, row ROWS-1 = bottom)
COLS, 10, board columns
SCORE_W, 20, width of score accumulator

Ports:
clk_50  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle request to process board_in; sampled only in IDLE
board_in  in  ROWS*COLS  current board; row j = bits [j*COLS +: COLS], bit c of that slice = column c
clear_score  in  1  synchronous zeroing of score and total_lines (new game)
busy  out  1  high from the cycle after start is accepted until done is asserted (inclusive)
board_out  out  ROWS*COLS  compacted board, valid while board_we=1
board_we  out  1  one-cycle write strobe for board_out
done  out  1  one-cycle completion pulse
lines_cleared  out  5  rows removed in the last operation; valid from the done cycle until the next start
score  out  SCORE_W  accumulated score, saturating
total_lines  out  16  accumulated cleared rows, saturating

Behaviour:
- Reset state:
  - All outputs 0; state IDLE; internal board copy 0; row pointer ROWS-1.
- Reset mid-operation:
  - Aborts the operation; no board_we or done is issued.
- FSM states: IDLE, CHECK, SHIFT, WRITE, DONE.
- IDLE:
  - On start=1, capture board_in into the internal copy, set row pointer r=ROWS-1, clear the line counter, and go to CHECK.
  - start in any other state is ignored; it is neither queued nor restarted.
- CHECK (1 cycle per row):
  - If row r is all ones (full), go to SHIFT.
  - Else if r==0, go to WRITE.
  - Else r<=r-1 and stay in CHECK.
- SHIFT (1 cycle):
  - For k=r down to 1, row k<=row k-1; row 0<=0.
  - Line counter +1.
  - Return to CHECK with r unchanged, so the row shifted into r is rechecked.
  - If r==0, the cleared row 0 is rechecked, found empty, and the FSM proceeds to WRITE.
- WRITE (1 cycle):
  - board_we=1 with board_out = internal copy.
  - board_out holds its value until the next WRITE.
- DONE (1 cycle):
  - done=1 and lines_cleared = counter.
  - score += points(counter); total_lines += counter.
  - Return to IDLE.
- Points table: 0->0, 1->40, 2->100, 3->300, >=4->1200.
- Saturation: score saturates at 2^SCORE_W-1; total_lines saturates at 65535.
- clear_score:
  - Zeroes score and total_lines in any state.
  - If asserted in the DONE cycle, clear wins and no addition is made.
- Latency from the start cycle (cycle 0), with N rows cleared:
  - CHECK occupies cycles 1..23+2N interleaved with SHIFT.
  - WRITE at cycle 24+2N; done at cycle 25+2N.
- Counter widths:
  - The line counter is 5 bits and cannot overflow; at most ROWS rows can be cleared.
  - An all-full board yields 23 lines and an all-zero board.
- Boundary conditions:
  - Empty board: no SHIFT; board_out equals board_in.
  - Full row at row 0: handled as described under SHIFT.
  - Non-contiguous full rows: each is removed, and the order of the remaining rows is preserved.

Test Plan:
1. Empty board, start at cycle 0 -> board_we at cycle 24 with board_out=0, done at cycle 25, lines_cleared=0, score=0, busy high cycles 1..25.
2. Row 22 = 0x3FF, row 21 = 0x201, rest 0 -> done at cycle 27, lines_cleared=1, board_out row 22 = 0x201, row 21 = 0, score=40, total_lines=1.
3. Rows 19..22 full, row 18 = 0x00F -> done at cycle 33, lines_cleared=4, board_out row 22 = 0x00F, all other rows 0, score +=1200.
4. Rows 22 and 20 full, row 21 = 0x0F0, row 19 = 0x001 -> lines_cleared=2, board_out row 22 = 0x0F0, row 21 = 0x001, rest 0, score +=100; a second start pulse at cycle 5 has no effect.
5. Reset asserted at cycle 10 of a scan -> next cycle busy=0; no board_we or done follows; score and total_lines = 0; a new start then completes normally.
6. Preload score near 2^20-1 via repeated 4-line clears, then one more 4-line clear -> score = 1048575 (saturated); clear_score in the same DONE cycle -> score=0, total_lines=0.
